// File: rtl/rf_write_scheduler.sv
`timescale 1ns/1ps
// rf_write_scheduler: arbitrates the single register-file write port between
// the pipeline write-back stage and buffered long-latency completions. It also
// keeps a pending-destination scoreboard for decode hazard checks.
// Optional starvation guard: define RF_SCHED_STARVE_EN.
module rf_write_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic        rf_we,
  output logic [4:0]  rf_wreg,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  // Elaboration-time parameter sanity checks
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_limit_chk
    $error("STARVE_LIMIT must be >= 1");
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lu_entry_t;

  lu_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  lu_entry_t        head;

  logic             fifo_grant;
  logic             wb_grant;
  logic [4:0]       sel_reg;
  logic [31:0]      sel_data;
  logic             src_fifo;

  logic [31:0]      pending;
  logic [31:0]      pending_set;
  logic [31:0]      pending_clr;

  // FIFO status; the extra pointer bit separates full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign lu_ready   = !fifo_full;
  assign push       = lu_valid && !fifo_full;
  assign pop        = fifo_grant;
  assign head       = fifo_mem[rd_ptr[ADDR_W-1:0]];

  // Write-port grant selection
  always_comb begin
    fifo_grant = 1'b0;
    wb_grant   = 1'b0;
    sel_reg    = head.rd;
    sel_data   = head.data;
`ifdef RF_SCHED_STARVE_EN
    if (!fifo_empty && (pipe_stall || !wb_valid)) begin
      fifo_grant = 1'b1;
    end else if (wb_valid) begin
      wb_grant = 1'b1;
    end
`else
    if (wb_valid) begin
      wb_grant = 1'b1;
    end else if (!fifo_empty) begin
      fifo_grant = 1'b1;
    end
`endif
    if (wb_grant) begin
      sel_reg  = wb_reg;
      sel_data = wb_data;
    end
  end

  // Completion buffer storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[ADDR_W-1:0]] <= '{rd: lu_reg, data: lu_data};
    end
  end

  // Completion buffer pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Registered write port; writes to r0 are consumed but suppressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_wreg  <= 5'd0;
      rf_wdata <= 32'd0;
      src_fifo <= 1'b0;
    end else begin
      rf_we    <= (fifo_grant || wb_grant) && (sel_reg != 5'd0);
      src_fifo <= fifo_grant;
      if (fifo_grant || wb_grant) begin
        rf_wreg  <= sel_reg;
        rf_wdata <= sel_data;
      end
    end
  end

  // Scoreboard set/clear vectors; clear tracks the commit of a buffered write
  always_comb begin
    pending_set = 32'd0;
    pending_clr = 32'd0;
    if (rf_we && src_fifo) pending_clr[rf_wreg] = 1'b1;
    if (iss_valid && (iss_reg != 5'd0)) pending_set[iss_reg] = 1'b1;
  end

  // Scoreboard register; a same-cycle set overrides the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 32'd0;
    end else begin
      pending <= ((pending & ~pending_clr) | pending_set) & 32'hFFFF_FFFE;
    end
  end

  // Decode hazard query; r0 is never pending
  assign hazard = ((chk_rs != 5'd0) && pending[chk_rs]) ||
                  ((chk_rt != 5'd0) && pending[chk_rt]) ||
                  ((chk_rd != 5'd0) && pending[chk_rd]);

`ifdef RF_SCHED_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  // Blocked-cycle count for a waiting FIFO head, saturating at the limit
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (fifo_empty || fifo_grant) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Starvation counter and pipeline freeze request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      if (pipe_stall && fifo_grant) begin
        pipe_stall <= 1'b0;
      end else if (starve_cnt_nxt == CNT_W'(STARVE_LIMIT)) begin
        pipe_stall <= 1'b1;
      end
    end
  end
`else
  assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for rf_write_scheduler: directed vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_rf_write_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
  logic        pipe_stall;

  rf_write_scheduler #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd), .hazard(hazard),
    .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata), .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend [32];
  bit          m_we;
  bit          m_src;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          m_stall;
`ifdef RF_SCHED_STARVE_EN
  int          m_cnt;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 1'b0; m_src = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_stall = 1'b0;
`ifdef RF_SCHED_STARVE_EN
    m_cnt = 0;
`endif
  endtask

  function automatic bit model_hazard();
    return ((chk_rs != 5'd0) && m_pend[chk_rs]) ||
           ((chk_rt != 5'd0) && m_pend[chk_rt]) ||
           ((chk_rd != 5'd0) && m_pend[chk_rd]);
  endfunction

  // Advance the model across one posedge using the currently driven inputs
  task automatic model_step();
    bit   was_empty;
    bit   fg;
    bit   push_ok;
    ent_t e;
    was_empty = (mq.size() == 0);
    push_ok   = lu_valid && (mq.size() < DEPTH);
`ifdef RF_SCHED_STARVE_EN
    fg = !was_empty && (m_stall || !wb_valid);
`else
    fg = !was_empty && !wb_valid;
`endif
    if (m_we && m_src) m_pend[m_reg] = 1'b0;
    if (iss_valid && (iss_reg != 5'd0)) m_pend[iss_reg] = 1'b1;
`ifdef RF_SCHED_STARVE_EN
    if (was_empty || fg) m_cnt = 0;
    else if (m_cnt < LIMIT) m_cnt++;
    if (m_stall && fg) m_stall = 1'b0;
    else if (m_cnt == LIMIT) m_stall = 1'b1;
`endif
    if (fg) begin
      e = mq.pop_front();
      m_we = (e.rd != 5'd0); m_reg = e.rd; m_data = e.data; m_src = 1'b1;
    end else if (wb_valid) begin
      m_we = (wb_reg != 5'd0); m_reg = wb_reg; m_data = wb_data; m_src = 1'b0;
    end else begin
      m_we = 1'b0; m_src = 1'b0;
    end
    if (push_ok) begin
      e.rd = lu_reg; e.data = lu_data;
      mq.push_back(e);
    end
  endtask

  task automatic compare_all();
    check("rf_we", rf_we, m_we);
    if (m_we) begin
      check("rf_wreg", rf_wreg, m_reg);
      check("rf_wdata", rf_wdata, m_data);
    end
    check("pipe_stall", pipe_stall, m_stall);
    check("lu_ready", lu_ready, mq.size() < DEPTH);
    check("hazard", hazard, model_hazard());
  endtask

  // WB is withheld while the model says the pipeline is frozen
  task automatic drive(input bit wbv, input logic [4:0] wbr, input logic [31:0] wbd,
                       input bit luv, input logic [4:0] lur, input logic [31:0] lud,
                       input bit issv, input logic [4:0] issr,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    wb_valid = wbv && !m_stall; wb_reg = wbr; wb_data = wbd;
    lu_valid = luv; lu_reg = lur; lu_data = lud;
    iss_valid = issv; iss_reg = issr;
    chk_rs = rs; chk_rt = rt; chk_rd = rd;
  endtask

  task automatic idle(input logic [4:0] rs);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, rs, 5'd0, 5'd0);
  endtask

  task automatic run_cycle();
    #1;
    compare_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (mq.size() == 0 && !m_we) break;
      idle(5'd0);
      run_cycle();
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit wbv; logic [4:0] wbr; logic [31:0] wbd;
    bit luv; logic [4:0] lur; logic [31:0] lud;
    bit issv; logic [4:0] issr;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] rd;
    bit e_we; logic [4:0] e_reg; logic [31:0] e_data; bit e_haz; bit e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit wbv, logic [4:0] wbr, logic [31:0] wbd,
                              bit luv, logic [4:0] lur, logic [31:0] lud,
                              bit issv, logic [4:0] issr,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              bit e_we, logic [4:0] e_reg, logic [31:0] e_data,
                              bit e_haz, bit e_rdy);
    vec_t v;
    v.wbv = wbv; v.wbr = wbr; v.wbd = wbd;
    v.luv = luv; v.lur = lur; v.lud = lud;
    v.issv = issv; v.issr = issr;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data; v.e_haz = e_haz; v.e_rdy = e_rdy;
    return v;
  endfunction

  initial begin
    // basic flow: issue r5, complete r5, write, hazard release
    tbl.push_back(mk(0,0,0,           0,0,0,              1,5, 5,0,0, 0,0,0,            0,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 5,0,0, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           1,5,32'hDEADBEEF,   0,0, 5,0,0, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 5,0,0, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 5,0,0, 1,5,32'hDEADBEEF, 1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 5,0,0, 0,0,0,            0,1));
    // priority: WB r3 beats buffered r7
    tbl.push_back(mk(0,0,0,           1,7,32'h77,         0,0, 0,0,0, 0,0,0,            0,1));
    tbl.push_back(mk(1,3,32'h11,      0,0,0,              0,0, 0,0,0, 0,0,0,            0,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 0,0,0, 1,3,32'h11,       0,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 0,0,0, 1,7,32'h77,       0,1));
    // r0 completion: popped, never written
    tbl.push_back(mk(0,0,0,           1,0,32'hAAAA,       0,0, 0,0,0, 0,0,0,            0,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 0,0,0, 0,0,0,            0,1));
    // set/clear collision on r9
    tbl.push_back(mk(0,0,0,           0,0,0,              1,9, 0,0,0, 0,0,0,            0,1));
    tbl.push_back(mk(0,0,0,           1,9,32'h99,         0,0, 9,0,0, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 9,0,0, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              1,9, 9,0,0, 1,9,32'h99,       1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 0,9,0, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           1,9,32'h9A,         0,0, 0,0,9, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 9,0,0, 0,0,0,            1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 9,0,0, 1,9,32'h9A,       1,1));
    tbl.push_back(mk(0,0,0,           0,0,0,              0,0, 9,0,0, 0,0,0,            0,1));

    // ---------------- reset state ----------------
    model_reset();
    reset = 1'b1;
    idle(5'd0);
    #12;
    check("reset.rf_we", rf_we, 1'b0);
    check("reset.rf_wreg", rf_wreg, 5'd0);
    check("reset.rf_wdata", rf_wdata, 32'd0);
    check("reset.pipe_stall", pipe_stall, 1'b0);
    check("reset.lu_ready", lu_ready, 1'b1);
    check("reset.hazard", hazard, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      drive(tbl[i].wbv, tbl[i].wbr, tbl[i].wbd, tbl[i].luv, tbl[i].lur, tbl[i].lud,
            tbl[i].issv, tbl[i].issr, tbl[i].rs, tbl[i].rt, tbl[i].rd);
      #1;
      check($sformatf("vec%0d.rf_we", i), rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        check($sformatf("vec%0d.rf_wreg", i), rf_wreg, tbl[i].e_reg);
        check($sformatf("vec%0d.rf_wdata", i), rf_wdata, tbl[i].e_data);
      end
      check($sformatf("vec%0d.hazard", i), hazard, tbl[i].e_haz);
      check($sformatf("vec%0d.lu_ready", i), lu_ready, tbl[i].e_rdy);
      compare_all();
      model_step();
      @(negedge clk);
    end
    drain();

    // ---------------- full FIFO under continuous WB ----------------
    for (int i = 0; i < 8; i++) begin
      logic [4:0] lr;
      lr = (i < 4) ? 5'(20 + i) : 5'd24;
      drive(i < 6, 5'(i + 1), 32'h100 + 32'(i), 1, lr, 32'hF000 + 32'(lr),
            0, 5'd0, 5'd0, 5'd0, 5'd0);
      #1;
      check($sformatf("full%0d.lu_ready", i), lu_ready, (i < 4 || i == 7) ? 1'b1 : 1'b0);
      compare_all();
      model_step();
      @(negedge clk);
    end
    drain();

`ifdef RF_SCHED_STARVE_EN
    // ---------------- starvation guard ----------------
    drive(1, 5'd1, 32'h1, 1, 5'd12, 32'hC0DE, 0, 5'd0, 5'd0, 5'd0, 5'd0);
    run_cycle();
    for (int k = 1; k <= 11; k++) begin
      drive(1, 5'(k + 1), 32'h200 + 32'(k), 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
      #1;
      check($sformatf("starve%0d.pipe_stall", k), pipe_stall, k == 9);
      if (k == 10) begin
        check("starve.rf_we", rf_we, 1'b1);
        check("starve.rf_wreg", rf_wreg, 5'd12);
        check("starve.rf_wdata", rf_wdata, 32'hC0DE);
      end
      compare_all();
      model_step();
      @(negedge clk);
    end
    drain();
`endif

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 800; c++) begin
      int wb_pct;
      wb_pct = (c >= 300 && c < 450) ? 95 : 55;
      drive($urandom_range(0, 99) < wb_pct, 5'($urandom), $urandom,
            $urandom_range(0, 99) < 40, 5'($urandom), $urandom,
            $urandom_range(0, 99) < 25, 5'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom));
      run_cycle();
    end
    drain();

    // ---------------- reset mid-operation ----------------
    drive(1, 5'd1, 32'h301, 0, 5'd0, 32'd0, 1, 5'd17, 5'd0, 5'd0, 5'd0);
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd1, 32'h302, 1, 5'(17 + i), 32'h400 + 32'(i), 0, 5'd0, 5'd0, 5'd0, 5'd0);
      run_cycle();
    end
    drive(1, 5'd2, 32'h303, 0, 5'd0, 32'd0, 0, 5'd0, 5'd17, 5'd0, 5'd0);
    #1;
    compare_all();
    idle(5'd17);
    #1;
    reset = 1'b1;
    #1;
    check("midreset.rf_we", rf_we, 1'b0);
    check("midreset.lu_ready", lu_ready, 1'b1);
    check("midreset.hazard", hazard, 1'b0);
    check("midreset.pipe_stall", pipe_stall, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(5'd17);
      #1;
      check($sformatf("postreset%0d.rf_we", i), rf_we, 1'b0);
      compare_all();
      model_step();
      @(negedge clk);
    end

    // ---------------- short random tail after reset ----------------
    for (int c = 0; c < 150; c++) begin
      drive($urandom_range(0, 99) < 50, 5'($urandom), $urandom,
            $urandom_range(0, 99) < 45, 5'($urandom), $urandom,
            $urandom_range(0, 99) < 30, 5'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom));
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
